// File: rtl/hue_ramp_pkg.sv
// Shared types and per-segment lookups for the hue_ramp colour-wheel generator.
package hue_pkg;

  typedef enum logic [2:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  function automatic chan_e ramp_chan(input phase_e p);
    case (p)
      PH_G_UP, PH_G_DN: return CH_G;
      PH_R_DN, PH_R_UP: return CH_R;
      default:          return CH_B;
    endcase
  endfunction

  function automatic logic ramp_up(input phase_e p);
    return (p == PH_G_UP) || (p == PH_B_UP) || (p == PH_R_UP);
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    return (p == PH_B_DN) ? PH_G_UP : phase_e'(p + 3'd1);
  endfunction

endpackage

// File: rtl/hue_ramp_step_timer.sv
// Step prescaler: tick is high on the enabled cycle where the count reaches INTERVAL-1.
module step_timer #(
  parameter int unsigned INTERVAL = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(INTERVAL - 1);

  if (INTERVAL < 2) begin : g_bad_interval
    $error("step_timer: INTERVAL must be at least 2");
  end

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/hue_ramp.sv
// Colour-wheel duty generator: six ramp segments, one channel moving per step,
// all outputs registered.
module hue_ramp
  import hue_pkg::*;
#(
  parameter  int unsigned PWM_INTERVAL  = 1200,
  parameter  int unsigned STEP_SIZE     = 20,
  parameter  int unsigned STEP_INTERVAL = 200000,
  localparam int unsigned DW            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [DW-1:0] r_duty,
  output logic [DW-1:0] g_duty,
  output logic [DW-1:0] b_duty,
  output logic [2:0]    phase,
  output logic          step_strobe
);

  localparam int unsigned N  = PWM_INTERVAL / STEP_SIZE;
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);
  localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP = DW'(STEP_SIZE);

  if (PWM_INTERVAL % STEP_SIZE != 0) begin : g_bad_step
    $error("hue_ramp: PWM_INTERVAL must be a multiple of STEP_SIZE");
  end

  logic          tick;
  phase_e        phase_q;
  logic [SW-1:0] step_cnt;
  chan_e         ch;
  logic          up;
  logic          last_step;
  logic [DW-1:0] cur;
  logic [DW-1:0] nxt;

  step_timer #(.INTERVAL(STEP_INTERVAL)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // The final step loads the terminal value rather than adding, which pins the
  // channel exactly to 0 or full scale at each segment boundary.
  always_comb begin
    ch        = ramp_chan(phase_q);
    up        = ramp_up(phase_q);
    last_step = (step_cnt == LAST_STEP);
    case (ch)
      CH_R:    cur = r_duty;
      CH_G:    cur = g_duty;
      default: cur = b_duty;
    endcase
    if (last_step) nxt = up ? FULL : '0;
    else           nxt = up ? cur + STEP : cur - STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_G_UP;
      step_cnt    <= '0;
      r_duty      <= FULL;
      g_duty      <= '0;
      b_duty      <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= tick;
      if (tick) begin
        case (ch)
          CH_R:    r_duty <= nxt;
          CH_G:    g_duty <= nxt;
          default: b_duty <= nxt;
        endcase
        if (last_step) begin
          phase_q  <= next_phase(phase_q);
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_hue_ramp.sv
// Directed bench for hue_ramp (PWM_INTERVAL=12, STEP_SIZE=4, STEP_INTERVAL=5)
// with a queue of expected strobe events checked by an independent monitor.
module tb_hue_ramp;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] r_duty, g_duty, b_duty;
  logic [2:0]    phase;
  logic          step_strobe;

  typedef struct {
    int r;
    int g;
    int b;
    int ph;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   en_cnt = 0;
  logic prev_strobe = 1'b0;
  bit   done = 1'b0;

  // Hand-computed states after each of the 18 steps of one hue cycle.
  int tab_r[18] = '{12,12,12, 8, 4, 0, 0, 0, 0, 0, 0, 0, 4, 8,12,12,12,12};
  int tab_g[18] = '{ 4, 8,12,12,12,12,12,12,12, 8, 4, 0, 0, 0, 0, 0, 0, 0};
  int tab_b[18] = '{ 0, 0, 0, 0, 0, 0, 4, 8,12,12,12,12,12,12,12, 8, 4, 0};
  int tab_p[18] = '{ 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5, 0};

  hue_ramp #(
    .PWM_INTERVAL  (12),
    .STEP_SIZE     (4),
    .STEP_INTERVAL (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .r_duty      (r_duty),
    .g_duty      (g_duty),
    .b_duty      (b_duty),
    .phase       (phase),
    .step_strobe (step_strobe)
  );

  always #5 clk = ~clk;

  // Enabled edges since the last reset; a strobe after edge k is seen with en_cnt == k.
  always @(posedge clk) begin
    if (reset)       en_cnt = 0;
    else if (enable) en_cnt = en_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input int r, input int g, input int b, input int ph);
    chk({name, ".r"}, int'(r_duty), r);
    chk({name, ".g"}, int'(g_duty), g);
    chk({name, ".b"}, int'(b_duty), b);
    chk({name, ".phase"}, int'(phase), ph);
  endtask

  task automatic push_step(input int k, input int cyc);
    exp_t e;
    e.r = tab_r[k]; e.g = tab_g[k]; e.b = tab_b[k]; e.ph = tab_p[k]; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      if (step_strobe) begin
        tests++;
        if (prev_strobe) begin
          fails++;
          $display("FAIL strobe_consecutive: got 1 expected 0 at t=%0t", $time);
        end
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL strobe_unexpected: got strobe expected none at t=%0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk_state("step", e.r, e.g, e.b, e.ph);
          chk("step.cycle", en_cnt, e.cyc);
        end
      end
      prev_strobe = step_strobe;
    end
  end

  initial begin
    // Reset held, then released with enable low: nothing moves.
    cycles(3);
    reset = 1'b0;
    cycles(8);
    chk_state("idle", 12, 0, 0, 0);
    chk("idle.strobe", int'(step_strobe), 0);

    // One full hue cycle: 18 steps, 5 enabled clocks apart.
    for (int k = 0; k < 18; k++) push_step(k, 5 * (k + 1));
    enable = 1'b1;
    cycles(90);
    enable = 1'b0;
    cycles(1);
    chk_state("wrap", 12, 0, 0, 0);

    // Start fresh, run 3 enabled cycles, freeze for 20, then resume.
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    enable = 1'b1;
    cycles(3);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (i % 5 == 4) chk_state("frozen", 12, 0, 0, 0);
    end
    push_step(0, 5);
    enable = 1'b1;
    cycles(2);
    chk_state("resume", 12, 4, 0, 0);

    // Advance to phase 3 with g=8 (step index 9), then two cycles into the segment.
    for (int k = 1; k < 10; k++) push_step(k, 5 * (k + 1));
    cycles(45);
    chk_state("ph3", 0, 8, 12, 3);
    cycles(2);

    // Single-cycle reset mid-segment with enable still high.
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk_state("midreset", 12, 0, 0, 0);
    push_step(0, 5);
    cycles(5);
    chk_state("post_reset", 12, 4, 0, 0);

    // Enable dropped exactly on the step edge: the step is withheld.
    cycles(4);
    enable = 1'b0;
    cycles(3);
    chk_state("held_step", 12, 4, 0, 0);
    push_step(1, 10);
    enable = 1'b1;
    cycles(1);
    chk_state("late_step", 12, 8, 0, 0);

    // Reset held with enable high never strobes.
    reset = 1'b1;
    cycles(12);
    chk_state("hold_reset", 12, 0, 0, 0);
    chk("hold_reset.strobe", int'(step_strobe), 0);
    reset = 1'b0;
    enable = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
    chk("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hue_ramp.md
# hue_ramp

Color-wheel duty-cycle generator for the RGB LED mini-project. It sweeps hue through six 60° segments and produces red, green and blue duty values. Each value feeds one downstream PWM stage built with the same `PWM_INTERVAL`. It replaces the single-channel triangle fade: the PWM stages consume its outputs unchanged, and the three PWM outputs drive the LED pins.

## Interface

- `PWM_INTERVAL`, 1200: full-scale duty value, equal to the downstream PWM period in clocks.
- `STEP_SIZE`, 20: amount a ramping channel changes per step. `PWM_INTERVAL % STEP_SIZE == 0` is required; violation is an elaboration `$error`.
- `STEP_INTERVAL`, 200000: clocks between steps. Must be ≥ 2, else elaboration `$error`. With a 12 MHz clock this gives 1 s per segment and 6 s per full hue cycle.
- Derived `DW = $clog2(PWM_INTERVAL+1)`.
- Derived `N = PWM_INTERVAL/STEP_SIZE`, the steps per segment.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `enable`, input, 1: when low, timer and outputs freeze.
- `r_duty`, output, DW: red duty, 0..PWM_INTERVAL.
- `g_duty`, output, DW: green duty.
- `b_duty`, output, DW: blue duty.
- `phase`, output, 3: current segment, 0..5.
- `step_strobe`, output, 1: one-cycle pulse in the first cycle new duty values are visible.

## Operation

Segments (`phase`), listed as held channels / ramping channel:
- 0: R=max, B=0 / G ramps up.
- 1: G=max, B=0 / R ramps down.
- 2: G=max, R=0 / B ramps up.
- 3: B=max, R=0 / G ramps down.
- 4: B=max, G=0 / R ramps up.
- 5: R=max, G=0 / B ramps down.

State and counters:
- Reset values: `phase`=0, `r_duty`=PWM_INTERVAL, `g_duty`=0, `b_duty`=0, `step_strobe`=0, tick counter 0, segment step counter 0.
- The tick counter counts 0..STEP_INTERVAL-1 while `enable`=1, then wraps to 0. A step occurs on the edge where the counter equals STEP_INTERVAL-1 and `enable`=1.
- On a non-final step (step counter < N-1): the ramping channel moves by ±STEP_SIZE, and the step counter increments.
- On the final step (step counter = N-1): the ramping channel is loaded with its terminal value (PWM_INTERVAL or 0), `phase` advances (5 wraps to 0), and the step counter clears.
- After a step, the first ramp in the new segment starts one step later. No step is skipped or duplicated at a segment boundary.

Invariants:
- Exactly one channel changes per step, by exactly STEP_SIZE.
- Duty values never leave 0..PWM_INTERVAL.
- At most one channel is strictly between 0 and max.
- Width: ramping arithmetic is done in DW bits. Overflow is impossible given the divisibility check.

## Timing

- All outputs are registered. No combinational path from `enable` or `reset` to any output.
- After `reset` deasserts, the first step edge is the STEP_INTERVAL-th rising edge with `enable`=1. New values and `step_strobe` are visible in the following cycle.
- `step_strobe` is high for exactly one cycle per step and never on two consecutive cycles.
- `enable` low: tick counter, step counter, phase and duties all hold, and `step_strobe`=0. Re-enabling resumes from the held count; accumulated enabled cycles are preserved.
- `enable` dropping on the step edge itself means no step occurs.
- `reset` has priority over `enable`. Asserting it mid-segment returns all state to reset values on the next edge. `reset` held with `enable`=1 produces no strobe.
- Full hue cycle = 6·N·STEP_INTERVAL enabled clocks. The cycle ends in the exact reset state, excluding `step_strobe`.

## Structure

- Package `hue_pkg`:
  - enum `phase_e` (PH_G_UP, PH_R_DN, PH_B_UP, PH_G_DN, PH_R_UP, PH_B_DN), encoded 0..5.
  - per-phase lookup functions returning the ramping channel and its direction.
- Sub-module `step_timer` (parameter INTERVAL; ports `clk`, `reset`, `enable`, `tick`): the prescaler. `hue_ramp` holds the segment FSM, step counter and duty registers.
- Integration: three existing PWM instances with `PWM_INTERVAL` taken from the same parameter.

## Test plan

Directed scenarios use PWM_INTERVAL=12, STEP_SIZE=4, STEP_INTERVAL=5 (so N=3) unless noted.

1. Reset held 3 cycles, then released, `enable`=0 → r=12, g=0, b=0, phase=0, strobe never asserts.
2. `enable`=1 from release → strobe at cycles 5/10/15 with g=4/8/12. phase=1 from cycle 15. Next strobe at cycle 20 gives r=8.
3. 90 enabled cycles (18 steps) → returns to r=12, g=0, b=0, phase=0. At every strobe exactly one channel changed by 4 and all values stay within 0..12.
4. `enable` dropped for 20 cycles after 3 enabled cycles → outputs frozen. Next strobe arrives 2 enabled cycles after re-enable.
5. `reset` pulsed for one cycle during phase 3 with g=8 → next cycle r=12, g=0, b=0, phase=0. Next strobe occurs 5 enabled cycles later.
6. Default parameters → first strobe at enabled cycle 200000 with g=20. The phase 0→1 transition occurs at cycle 12,000,000.
